// File: rtl/mem_stage.sv
// mem_stage: load/store memory stage with an IDLE/WAIT request FSM, ack timeout and
// registered writeback outputs. Define MISALIGN_TRAP_EN to trap misaligned accesses.
`ifndef XLEN
`define XLEN 32
`endif
`ifndef XADDR
`define XADDR 5
`endif
`ifndef OPLEN
`define OPLEN 6
`endif
`ifndef L_OP
`define L_OP 7'b0000011
`endif
`ifndef S_OP
`define S_OP 7'b0100011
`endif
`ifndef B_OP
`define B_OP 7'b1100011
`endif
`ifndef JAL_OP
`define JAL_OP 7'b1101111
`endif
`ifndef JALR_OP
`define JALR_OP 7'b1100111
`endif

module mem_stage #(
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_valid,
  input  logic [`OPLEN:0]      i_opcode,
  input  logic [2:0]           i_funct3,
  input  logic [`XADDR-1:0]    i_rd_addr,
  input  logic [`XLEN-1:0]     i_alu_result,
  input  logic [`XLEN-1:0]     i_rs2_data,
  input  logic [`XLEN-1:0]     i_pc,
  output logic                 o_stall,
  output logic                 o_mem_req,
  output logic                 o_mem_we,
  output logic [`XLEN-1:0]     o_mem_addr,
  output logic [`XLEN-1:0]     o_mem_wdata,
  output logic [3:0]           o_mem_wstrb,
  input  logic                 i_mem_ack,
  input  logic [`XLEN-1:0]     i_mem_rdata,
  output logic                 or_valid,
  output logic [`OPLEN:0]      or_opcode,
  output logic [`XADDR-1:0]    or_rd_addr,
  output logic [`XLEN-1:0]     or_rd_data,
  output logic                 or_rd_wr_en,
  output logic                 or_bus_err,
  output logic                 or_misaligned
);

  localparam int XL = `XLEN;
  localparam int OL = `OPLEN + 1;
  localparam int RL = `XADDR;
  localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);
  localparam logic [OL-1:0] OP_LOAD  = `L_OP;
  localparam logic [OL-1:0] OP_STORE = `S_OP;
  localparam logic [OL-1:0] OP_BR    = `B_OP;
  localparam logic [OL-1:0] OP_JAL   = `JAL_OP;
  localparam logic [OL-1:0] OP_JALR  = `JALR_OP;
  localparam logic [XL-1:0] LINK_INC = XL'(4);

  typedef enum logic {IDLE, WAIT} state_t;

  state_t          state_reg, state_next;
  logic [CW-1:0]   cnt_reg, cnt_next;

  // Captured request, held stable for the whole WAIT phase
  logic [XL-1:0]   alu_reg;
  logic [1:0]      off_reg;
  logic            we_reg;
  logic [XL-1:0]   wdata_reg;
  logic [3:0]      wstrb_reg;
  logic [2:0]      funct3_reg;
  logic [RL-1:0]   rd_reg;
  logic [OL-1:0]   opcode_reg;

  logic            valid_reg, valid_next;
  logic [OL-1:0]   out_opcode_reg, out_opcode_next;
  logic [RL-1:0]   out_rd_reg, out_rd_next;
  logic [XL-1:0]   data_reg, data_next;
  logic            wr_en_reg, wr_en_next;
  logic            bus_err_reg, bus_err_next;

  logic            is_load, is_store, is_mem, is_link, no_wb;
  logic            size_half, size_word, misaligned, issue;
  logic [1:0]      eff_off;
  logic            ack_done, timeout;
  logic [3:0]      st_wstrb;
  logic [XL-1:0]   st_wdata;
  logic [7:0]      rd_lane [4];
  logic [7:0]      load_byte;
  logic [15:0]     load_half;
  logic [XL-1:0]   load_data;

  assign is_load   = (i_opcode == OP_LOAD);
  assign is_store  = (i_opcode == OP_STORE);
  assign is_mem    = is_load || is_store;
  assign is_link   = (i_opcode == OP_JAL) || (i_opcode == OP_JALR);
  assign no_wb     = is_store || (i_opcode == OP_BR);
  assign size_half = (i_funct3[1:0] == 2'b01);
  assign size_word = i_funct3[1];

`ifdef MISALIGN_TRAP_EN
  assign misaligned = is_mem && ((size_half && i_alu_result[0]) ||
                                 (size_word && (i_alu_result[1:0] != 2'b00)));
`else
  assign misaligned = 1'b0;
`endif

  // Halves and words drop their low address bits; bytes keep the full offset
  always_comb begin
    eff_off = i_alu_result[1:0];
    if (size_word) begin
      eff_off = 2'b00;
    end else if (size_half) begin
      eff_off = {i_alu_result[1], 1'b0};
    end
  end

  assign issue    = (state_reg == IDLE) && i_valid && is_mem && !misaligned;
  assign ack_done = (state_reg == WAIT) && i_mem_ack;
  assign timeout  = (state_reg == WAIT) && !i_mem_ack && (cnt_reg == CNT_LAST);

  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    localparam logic [1:0] LANE = 2'(gi);
    assign st_wstrb[gi] = size_word ||
                          (size_half ? (eff_off[1] == LANE[1]) : (eff_off == LANE));
    assign st_wdata[8*gi +: 8] = size_word ? i_rs2_data[8*gi +: 8] :
                                 size_half ? i_rs2_data[8*(gi%2) +: 8] :
                                             i_rs2_data[7:0];
    assign rd_lane[gi] = i_mem_rdata[8*gi +: 8];
  end

  always_comb begin
    load_byte = rd_lane[off_reg];
    load_half = off_reg[1] ? i_mem_rdata[31:16] : i_mem_rdata[15:0];
    case (funct3_reg[1:0])
      2'b00:   load_data = {{(XL-8){!funct3_reg[2] && load_byte[7]}}, load_byte};
      2'b01:   load_data = {{(XL-16){!funct3_reg[2] && load_half[15]}}, load_half};
      default: load_data = i_mem_rdata;
    endcase
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    case (state_reg)
      IDLE: begin
        if (issue) begin
          state_next = WAIT;
          cnt_next   = '0;
        end
      end
      WAIT: begin
        if (ack_done || timeout) begin
          state_next = IDLE;
        end else if (cnt_reg != CNT_LAST) begin
          cnt_next = cnt_reg + CW'(1);
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Stall also drops on the timeout cycle so the aborted access is not re-presented
  assign o_stall = issue || ((state_reg == WAIT) && !i_mem_ack && !timeout);

  always_comb begin
    valid_next      = 1'b0;
    out_opcode_next = '0;
    out_rd_next     = '0;
    data_next       = '0;
    wr_en_next      = 1'b0;
    bus_err_next    = 1'b0;
    if (state_reg == IDLE) begin
      if (i_valid && !issue) begin
        valid_next      = 1'b1;
        out_opcode_next = i_opcode;
        out_rd_next     = i_rd_addr;
        data_next       = is_link ? (i_pc + LINK_INC) : i_alu_result;
        wr_en_next      = !no_wb && (i_rd_addr != '0) && !misaligned;
      end
    end else if (ack_done || timeout) begin
      valid_next      = 1'b1;
      out_opcode_next = opcode_reg;
      out_rd_next     = rd_reg;
      data_next       = ((opcode_reg == OP_LOAD) && ack_done) ? load_data : alu_reg;
      bus_err_next    = timeout;
      wr_en_next      = (opcode_reg != OP_STORE) && (opcode_reg != OP_BR) &&
                        (rd_reg != '0) && !timeout;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_reg  <= IDLE;
      cnt_reg    <= '0;
      alu_reg    <= '0;
      off_reg    <= '0;
      we_reg     <= 1'b0;
      wdata_reg  <= '0;
      wstrb_reg  <= '0;
      funct3_reg <= '0;
      rd_reg     <= '0;
      opcode_reg <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      if (issue) begin
        alu_reg    <= i_alu_result;
        off_reg    <= eff_off;
        we_reg     <= is_store;
        wdata_reg  <= is_store ? st_wdata : '0;
        wstrb_reg  <= is_store ? st_wstrb : 4'b0000;
        funct3_reg <= i_funct3;
        rd_reg     <= i_rd_addr;
        opcode_reg <= i_opcode;
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      valid_reg      <= 1'b0;
      out_opcode_reg <= '0;
      out_rd_reg     <= '0;
      data_reg       <= '0;
      wr_en_reg      <= 1'b0;
      bus_err_reg    <= 1'b0;
    end else begin
      valid_reg      <= valid_next;
      out_opcode_reg <= out_opcode_next;
      out_rd_reg     <= out_rd_next;
      data_reg       <= data_next;
      wr_en_reg      <= wr_en_next;
      bus_err_reg    <= bus_err_next;
    end
  end

`ifdef MISALIGN_TRAP_EN
  logic mis_reg;
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      mis_reg <= 1'b0;
    end else begin
      mis_reg <= (state_reg == IDLE) && i_valid && misaligned;
    end
  end
  assign or_misaligned = mis_reg;
`else
  assign or_misaligned = 1'b0;
`endif

  assign o_mem_req   = (state_reg == WAIT);
  assign o_mem_we    = we_reg;
  assign o_mem_addr  = {alu_reg[XL-1:2], 2'b00};
  assign o_mem_wdata = wdata_reg;
  assign o_mem_wstrb = wstrb_reg;

  assign or_valid    = valid_reg;
  assign or_opcode   = out_opcode_reg;
  assign or_rd_addr  = out_rd_reg;
  assign or_rd_data  = data_reg;
  assign or_rd_wr_en = wr_en_reg;
  assign or_bus_err  = bus_err_reg;

endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: table-driven and randomized checks of mem_stage against a
// behavioural model of the load/store rules.
`ifndef L_OP
`define L_OP 7'b0000011
`endif
`ifndef S_OP
`define S_OP 7'b0100011
`endif
`ifndef B_OP
`define B_OP 7'b1100011
`endif
`ifndef JAL_OP
`define JAL_OP 7'b1101111
`endif
`ifndef JALR_OP
`define JALR_OP 7'b1100111
`endif

module tb_mem_stage;
  localparam int TO = 64;
  localparam logic [6:0] L_OP    = `L_OP;
  localparam logic [6:0] S_OP    = `S_OP;
  localparam logic [6:0] B_OP    = `B_OP;
  localparam logic [6:0] JAL_OP  = `JAL_OP;
  localparam logic [6:0] JALR_OP = `JALR_OP;
  localparam logic [6:0] ALU_OP  = 7'b0110011;
  localparam logic [6:0] IMM_OP  = 7'b0010011;

  logic        i_clk, i_rst, i_valid;
  logic [6:0]  i_opcode;
  logic [2:0]  i_funct3;
  logic [4:0]  i_rd_addr;
  logic [31:0] i_alu_result, i_rs2_data, i_pc;
  logic        o_stall, o_mem_req, o_mem_we;
  logic [31:0] o_mem_addr, o_mem_wdata;
  logic [3:0]  o_mem_wstrb;
  logic        i_mem_ack;
  logic [31:0] i_mem_rdata;
  logic        or_valid, or_rd_wr_en, or_bus_err, or_misaligned;
  logic [6:0]  or_opcode;
  logic [4:0]  or_rd_addr;
  logic [31:0] or_rd_data;

  mem_stage #(.TIMEOUT_CYCLES(TO)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_valid(i_valid), .i_opcode(i_opcode),
    .i_funct3(i_funct3), .i_rd_addr(i_rd_addr), .i_alu_result(i_alu_result),
    .i_rs2_data(i_rs2_data), .i_pc(i_pc), .o_stall(o_stall), .o_mem_req(o_mem_req),
    .o_mem_we(o_mem_we), .o_mem_addr(o_mem_addr), .o_mem_wdata(o_mem_wdata),
    .o_mem_wstrb(o_mem_wstrb), .i_mem_ack(i_mem_ack), .i_mem_rdata(i_mem_rdata),
    .or_valid(or_valid), .or_opcode(or_opcode), .or_rd_addr(or_rd_addr),
    .or_rd_data(or_rd_data), .or_rd_wr_en(or_rd_wr_en), .or_bus_err(or_bus_err),
    .or_misaligned(or_misaligned)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        mis;
    logic [31:0] addr;
    logic [3:0]  wstrb;
    logic [31:0] wdata;
    logic [31:0] rd_data;
    logic        wr_en;
    logic        bus_err;
  } exp_t;

  typedef struct {
    logic [6:0]  op;
    logic [2:0]  f3;
    logic [4:0]  rd;
    logic [31:0] alu, rs2, pc, rdata;
    int          delay;   // WAIT cycles before ack; >= TO means no ack
    exp_t        e;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  function automatic vec_t mk(logic [6:0] op, logic [2:0] f3, logic [4:0] rd,
                              logic [31:0] alu, logic [31:0] rs2, logic [31:0] pc,
                              logic [31:0] rdata, int delay, logic mis, logic [31:0] addr,
                              logic [3:0] wstrb, logic [31:0] wdata, logic [31:0] rd_data,
                              logic wr_en, logic bus_err);
    vec_t v;
    v.op = op; v.f3 = f3; v.rd = rd; v.alu = alu; v.rs2 = rs2; v.pc = pc;
    v.rdata = rdata; v.delay = delay;
    v.e.mis = mis; v.e.addr = addr; v.e.wstrb = wstrb; v.e.wdata = wdata;
    v.e.rd_data = rd_data; v.e.wr_en = wr_en; v.e.bus_err = bus_err;
    return v;
  endfunction

  // Reference: access size in bytes, aligned by subtracting the remainder,
  // lanes extracted by shifting and masking, replication by multiplication.
  function automatic exp_t model(vec_t v);
    exp_t        e;
    int unsigned size, off;
    logic [31:0] eff, mask, raw;
    logic        mem, timeout;
    mem     = (v.op == L_OP) || (v.op == S_OP);
    timeout = (v.delay >= TO);
    size    = (v.f3[1:0] == 2'd0) ? 1 : (v.f3[1:0] == 2'd1) ? 2 : 4;
`ifdef MISALIGN_TRAP_EN
    e.mis = mem && ((v.alu % size) != 0);
`else
    e.mis = 1'b0;
`endif
    eff    = v.alu - (v.alu % size);
    off    = eff % 4;
    e.addr = eff - off;
    e.wstrb = (v.op == S_OP) ? 4'(((32'd1 << size) - 1) << off) : 4'd0;
    if (size == 1)      e.wdata = (v.rs2 & 32'hFF) * 32'h0101_0101;
    else if (size == 2) e.wdata = (v.rs2 & 32'hFFFF) * 32'h0001_0001;
    else                e.wdata = v.rs2;
    mask = (size == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * size)) - 1);
    raw  = (v.rdata >> (8 * off)) & mask;
    if (!v.f3[2] && size < 4 && raw > (mask >> 1)) raw = raw | ~mask;
    if (v.op == JAL_OP || v.op == JALR_OP) e.rd_data = v.pc + 4;
    else if (v.op == L_OP && !timeout && !e.mis) e.rd_data = raw;
    else e.rd_data = v.alu;
    e.bus_err = mem && !e.mis && timeout;
    e.wr_en   = (v.op != S_OP) && (v.op != B_OP) && (v.rd != 0) && !e.mis && !e.bus_err;
    return e;
  endfunction

  task automatic run_op(input vec_t v, input string tag);
    logic mem, store, issued, done_ack, done_to, finished;
    int   stall_cnt, req_pre;
    mem    = (v.op == L_OP) || (v.op == S_OP);
    store  = (v.op == S_OP);
    issued = mem && !v.e.mis;
    i_valid = 1'b1; i_opcode = v.op; i_funct3 = v.f3; i_rd_addr = v.rd;
    i_alu_result = v.alu; i_rs2_data = v.rs2; i_pc = v.pc;
    i_mem_rdata = v.rdata; i_mem_ack = 1'b0;
    #1;
    check({tag, ":stall_idle"}, o_stall, issued);
    check({tag, ":req_idle"}, o_mem_req, 1'b0);
    stall_cnt = 0;
    req_pre   = 0;
    finished  = !issued;
    tick();
    for (int w = 0; w < TO + 4 && !finished; w++) begin
      done_ack  = (w == v.delay);
      done_to   = !done_ack && (w == TO - 1);
      i_mem_ack = done_ack;
      #1;
      check({tag, ":req"}, o_mem_req, 1'b1);
      check({tag, ":addr"}, o_mem_addr, v.e.addr);
      check({tag, ":we"}, o_mem_we, store);
      if (store) begin
        check({tag, ":wstrb"}, o_mem_wstrb, v.e.wstrb);
        check({tag, ":wdata"}, o_mem_wdata, v.e.wdata);
      end
      check({tag, ":valid_wait"}, or_valid, 1'b0);
      if (o_stall) stall_cnt++;
      if (!done_ack && o_mem_req) req_pre++;
      tick();
      i_mem_ack = 1'b0;
      finished  = done_ack || done_to;
    end
    if (issued) begin
      check({tag, ":stall_cycles"}, stall_cnt, (v.delay >= TO) ? TO - 1 : v.delay);
      check({tag, ":req_cycles"}, req_pre, (v.delay >= TO) ? TO : v.delay);
    end
    i_valid = 1'b0;
    #1;
    check({tag, ":valid"}, or_valid, 1'b1);
    check({tag, ":opcode"}, or_opcode, v.op);
    check({tag, ":rd_addr"}, or_rd_addr, v.rd);
    check({tag, ":rd_data"}, or_rd_data, v.e.rd_data);
    check({tag, ":wr_en"}, or_rd_wr_en, v.e.wr_en);
    check({tag, ":bus_err"}, or_bus_err, v.e.bus_err);
    check({tag, ":misaligned"}, or_misaligned, v.e.mis);
    check({tag, ":req_done"}, o_mem_req, 1'b0);
    $display("txn %s op=%02h f3=%0d addr=%08h rd=%0d data=%08h wr_en=%0b err=%0b mis=%0b",
             tag, v.op, v.f3, v.alu, v.rd, or_rd_data, or_rd_wr_en, or_bus_err, or_misaligned);
    tick();
    check({tag, ":bubble_valid"}, or_valid, 1'b0);
    check({tag, ":bubble_err"}, or_bus_err, 1'b0);
  endtask

  vec_t tbl[14];
  vec_t rv;

  initial begin
    tbl[0]  = mk(L_OP, 3'd2, 5'd5, 32'h100, 0, 32'h40, 32'hDEADBEEF, 3,
                 0, 32'h100, 4'h0, 0, 32'hDEADBEEF, 1, 0);
    tbl[1]  = mk(L_OP, 3'd0, 5'd6, 32'h103, 0, 32'h44, 32'h80FF_0000, 0,
                 0, 32'h100, 4'h0, 0, 32'hFFFFFF80, 1, 0);
    tbl[2]  = mk(L_OP, 3'd4, 5'd6, 32'h103, 0, 32'h48, 32'h80FF_0000, 1,
                 0, 32'h100, 4'h0, 0, 32'h00000080, 1, 0);
    tbl[3]  = mk(S_OP, 3'd1, 5'd0, 32'h102, 32'h1234ABCD, 32'h4C, 0, 1,
                 0, 32'h100, 4'b1100, 32'hABCDABCD, 32'h102, 0, 0);
`ifdef MISALIGN_TRAP_EN
    tbl[4]  = mk(L_OP, 3'd2, 5'd7, 32'h101, 0, 32'h50, 32'h11223344, 2,
                 1, 32'h100, 4'h0, 0, 32'h101, 0, 0);
`else
    tbl[4]  = mk(L_OP, 3'd2, 5'd7, 32'h101, 0, 32'h50, 32'h11223344, 2,
                 0, 32'h100, 4'h0, 0, 32'h11223344, 1, 0);
`endif
    tbl[5]  = mk(JAL_OP, 3'd0, 5'd1, 32'h2000, 0, 32'h1000, 0, 0,
                 0, 0, 4'h0, 0, 32'h1004, 1, 0);
    tbl[6]  = mk(JALR_OP, 3'd0, 5'd2, 32'h3000, 0, 32'hFFFFFFFC, 0, 0,
                 0, 0, 4'h0, 0, 32'h0, 1, 0);
    tbl[7]  = mk(ALU_OP, 3'd0, 5'd0, 32'h55, 0, 32'h58, 0, 0,
                 0, 0, 4'h0, 0, 32'h55, 0, 0);
    tbl[8]  = mk(B_OP, 3'd0, 5'd3, 32'h77, 0, 32'h5C, 0, 0,
                 0, 0, 4'h0, 0, 32'h77, 0, 0);
    tbl[9]  = mk(L_OP, 3'd1, 5'd8, 32'h102, 0, 32'h60, 32'h8001_1234, 1,
                 0, 32'h100, 4'h0, 0, 32'hFFFF8001, 1, 0);
    tbl[10] = mk(L_OP, 3'd5, 5'd9, 32'h102, 0, 32'h64, 32'hABCD_0000, 0,
                 0, 32'h100, 4'h0, 0, 32'h0000ABCD, 1, 0);
    tbl[11] = mk(S_OP, 3'd0, 5'd4, 32'h101, 32'h000000A5, 32'h68, 0, 2,
                 0, 32'h100, 4'b0010, 32'hA5A5A5A5, 32'h101, 0, 0);
    tbl[12] = mk(S_OP, 3'd2, 5'd0, 32'h204, 32'hCAFEBABE, 32'h6C, 0, 4,
                 0, 32'h204, 4'b1111, 32'hCAFEBABE, 32'h204, 0, 0);
    // ack lands on the final counter value: normal completion wins
    tbl[13] = mk(L_OP, 3'd2, 5'd10, 32'h300, 0, 32'h70, 32'h0BADF00D, TO - 1,
                 0, 32'h300, 4'h0, 0, 32'h0BADF00D, 1, 0);

    i_rst = 1'b1; i_valid = 1'b0; i_opcode = '0; i_funct3 = '0; i_rd_addr = '0;
    i_alu_result = '0; i_rs2_data = '0; i_pc = '0; i_mem_ack = 1'b0; i_mem_rdata = '0;
    tick();
    tick();
    check("reset:valid", or_valid, 1'b0);
    check("reset:wr_en", or_rd_wr_en, 1'b0);
    check("reset:rd_data", or_rd_data, 32'h0);
    check("reset:bus_err", or_bus_err, 1'b0);
    check("reset:req", o_mem_req, 1'b0);
    check("reset:we", o_mem_we, 1'b0);
    check("reset:wstrb", o_mem_wstrb, 4'h0);
    check("reset:stall", o_stall, 1'b0);
    i_rst = 1'b0;
    tick();
    check("bubble:valid", or_valid, 1'b0);

    foreach (tbl[i]) run_op(tbl[i], $sformatf("tbl%0d", i));

    // No ack at all: bus error, then the following instruction proceeds
    run_op(mk(L_OP, 3'd2, 5'd11, 32'h400, 0, 32'h74, 32'h12345678, TO,
              0, 32'h400, 4'h0, 0, 32'h400, 0, 1), "timeout");
    run_op(mk(IMM_OP, 3'd0, 5'd12, 32'h99, 0, 32'h78, 0, 0,
              0, 0, 4'h0, 0, 32'h99, 1, 0), "after_timeout");

    // Reset in the middle of a store's WAIT phase, then a stale ack
    i_valid = 1'b1; i_opcode = S_OP; i_funct3 = 3'd2; i_rd_addr = 5'd0;
    i_alu_result = 32'h500; i_rs2_data = 32'h11112222; i_pc = 32'h7C;
    tick();
    check("rst_sw:req_before", o_mem_req, 1'b1);
    check("rst_sw:we_before", o_mem_we, 1'b1);
    tick();
    i_rst = 1'b1;
    #1;
    check("rst_sw:req", o_mem_req, 1'b0);
    check("rst_sw:we", o_mem_we, 1'b0);
    check("rst_sw:wstrb", o_mem_wstrb, 4'h0);
    check("rst_sw:valid", or_valid, 1'b0);
    i_valid = 1'b0;
    tick();
    tick();
    i_rst = 1'b0;
    i_mem_ack = 1'b1;
    tick();
    i_mem_ack = 1'b0;
    check("rst_sw:late_ack_valid", or_valid, 1'b0);
    check("rst_sw:late_ack_req", o_mem_req, 1'b0);
    tick();
    check("rst_sw:idle_valid", or_valid, 1'b0);
    $display("txn rst_sw reset during store WAIT, late ack ignored");
    run_op(tbl[0], "after_reset");

    for (int n = 0; n < 40; n++) begin
      case ($urandom_range(0, 6))
        0: begin rv.op = L_OP;
             case ($urandom_range(0, 4))
               0: rv.f3 = 3'd0; 1: rv.f3 = 3'd1; 2: rv.f3 = 3'd2; 3: rv.f3 = 3'd4;
               default: rv.f3 = 3'd5;
             endcase
           end
        1: begin rv.op = S_OP; rv.f3 = 3'($urandom_range(0, 2)); end
        2: begin rv.op = B_OP; rv.f3 = 3'($urandom); end
        3: begin rv.op = JAL_OP; rv.f3 = 3'($urandom); end
        4: begin rv.op = JALR_OP; rv.f3 = 3'd0; end
        5: begin rv.op = ALU_OP; rv.f3 = 3'($urandom); end
        default: begin rv.op = L_OP; rv.f3 = 3'd2; end
      endcase
      rv.rd    = 5'($urandom);
      rv.alu   = $urandom;
      rv.rs2   = $urandom;
      rv.pc    = $urandom;
      rv.rdata = $urandom;
      rv.delay = ($urandom_range(0, 19) == 0) ? TO : $urandom_range(0, 5);
      rv.e     = model(rv);
      run_op(rv, $sformatf("rnd%0d", n));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/mem_stage.md
MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 64, meaning the maximum number of cycles spent waiting for i_mem_ack before aborting.
REQ-002 SHALL have port i_clk, input, 1: the CPU clock.
REQ-003 SHALL have port i_rst, input, 1: reset, asynchronous, active-high.
REQ-004 SHALL have port i_valid, input, 1: the execute-stage outputs are valid this cycle.
REQ-005 SHALL have port i_opcode, input, `OPLEN+1: opcode from execute.
REQ-006 SHALL have port i_funct3, input, 3: access size/sign selector.
REQ-007 SHALL have port i_rd_addr, input, `XADDR: destination register address.
REQ-008 SHALL have port i_alu_result, input, `XLEN: ALU result; also the memory address for loads and stores.
REQ-009 SHALL have port i_rs2_data, input, `XLEN: store data.
REQ-010 SHALL have port i_pc, input, `XLEN: PC of the instruction.
REQ-011 SHALL have port o_stall, input-side output, 1: combinational; upstream holds its inputs while this is high.
REQ-012 SHALL have ports o_mem_req (1), o_mem_we (1), o_mem_addr (`XLEN, word aligned), o_mem_wdata (`XLEN) and o_mem_wstrb (4), all outputs: the data-memory request.
REQ-013 SHALL have ports i_mem_ack (1) and i_mem_rdata (`XLEN), both inputs: memory completion and read word.
REQ-014 SHALL have registered outputs to writeback/forwarding: or_valid (1), or_opcode (`OPLEN+1), or_rd_addr (`XADDR), or_rd_data (`XLEN), or_rd_wr_en (1), or_bus_err (1) and or_misaligned (1).

Function
REQ-015 SHALL implement an FSM with states IDLE, WAIT.
- IDLE with i_valid and opcode `L_OP/`S_OP: go to WAIT and register the request.
- WAIT with i_mem_ack: return to IDLE.
- WAIT with the counter at TIMEOUT_CYCLES-1 and no ack: return to IDLE.
REQ-016 SHALL drive o_mem_req high from the first cycle in WAIT until the cycle i_mem_ack is sampled; addr/we/wdata/wstrb SHALL stay stable throughout.
REQ-017 SHALL drive o_stall high in IDLE when a valid load/store is presented, and in WAIT when ack is low; o_stall SHALL be low in the ack cycle.
REQ-018 SHALL give a latency of 1 cycle for non-memory ops (registered pass-through) and a minimum of 2 cycles for load/store (zero-wait ack).
REQ-019 SHALL select or_rd_data as follows: `JAL_OP/`JALR_OP -> i_pc+4; `L_OP -> extended load data; all others -> i_alu_result.
REQ-020 SHALL extract load data by funct3 and addr[1:0]:
- LB/LH: sign-extend.
- LBU/LHU: zero-extend.
- LW: full word.
REQ-021 SHALL generate stores as follows:
- SB: wstrb=0001<<addr[1:0], byte replicated x4.
- SH: wstrb 0011 or 1100 by addr[1], half replicated x2.
- SW: wstrb 1111.
REQ-022 SHALL set or_rd_wr_en = or_valid AND opcode not `S_OP/`B_OP AND rd_addr!=0 AND no bus error/misalign.
REQ-023 SHALL, on timeout, pulse or_bus_err high for one cycle with or_valid=1 and or_rd_wr_en=0.
REQ-024 SHALL give ack priority over timeout when both occur in the same cycle (normal completion, no error).
REQ-025 SHALL drive or_valid=0 when i_valid=0 in IDLE (bubble), and also while in WAIT before ack/timeout.
REQ-026 SHALL reset the timeout counter on each entry to WAIT; the counter SHALL saturate and SHALL not wrap.

Reset
REQ-027 SHALL, on i_rst assertion, immediately force state IDLE, o_mem_req=0, o_mem_we=0, o_mem_wstrb=0 and counter=0, abandoning any pending access.
REQ-028 SHALL hold all or_* outputs at 0 while i_rst is high.
REQ-029 SHALL ignore an ack arriving after reset for a request issued before reset.

Configuration
REQ-030 SHALL, with MISALIGN_TRAP_EN defined, detect misalignment (LH/LHU/SH with addr[0]=1; LW/SW with addr[1:0]!=0), issue no memory request, and register or_misaligned=1, or_valid=1 and or_rd_wr_en=0 for one cycle with 1-cycle latency.
REQ-031 SHALL, without MISALIGN_TRAP_EN, clear the low address bits for halves (bit 0) and words (bits 1:0), proceed with the access, and tie or_misaligned to 0.

Verification
REQ-032 SHALL cover: LW at addr 0x100, ack after 3 cycles with rdata 0xDEADBEEF, rd=5 -> req held 3 cycles, stall for 4 cycles, then or_rd_data=0xDEADBEEF and or_rd_wr_en=1.
REQ-033 SHALL cover: LB at addr 0x103 with rdata 0x80FF_0000 -> or_rd_data=0xFFFFFF80; LBU at the same address -> 0x00000080.
REQ-034 SHALL cover: SH at addr 0x102 with rs2 0x1234ABCD -> wstrb=1100, wdata=0xABCDABCD, we=1, or_rd_wr_en=0.
REQ-035 SHALL cover: LW with no ack -> after 64 cycles, or_bus_err pulses once, req drops, and the next instruction proceeds.
REQ-036 SHALL cover: i_rst asserted during WAIT of an SW -> o_mem_req=0 in the same cycle, with no output after release.
REQ-037 SHALL cover: LW at addr 0x101 -> with MISALIGN_TRAP_EN, or_misaligned=1 and no req; without it, o_mem_addr=0x100.
